// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing with
// memory-wait timeout, external stall hold and a sticky trap state.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit ENABLE_JAL  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  input  logic       stall,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       mem_req,
  output logic       mem_we,
  output logic       trap,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [2:0] state_o
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R      = 3'd0,
    C_I      = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_JAL    = 3'd5
  } cls_t;

  state_t           r_state;
  state_t           w_next;
  cls_t             r_cls;
  cls_t             w_dec_cls;
  logic             w_dec_legal;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tmo;

  always_comb begin
    w_dec_cls   = C_R;
    w_dec_legal = 1'b1;
    case (opcode)
      7'b0110011: w_dec_cls = C_R;
      7'b0010011: w_dec_cls = C_I;
      7'b0000011: w_dec_cls = C_LOAD;
      7'b0100011: w_dec_cls = C_STORE;
      7'b1100011: w_dec_cls = C_BRANCH;
      7'b1101111: begin
        w_dec_cls   = C_JAL;
        w_dec_legal = ENABLE_JAL;
      end
      default:    w_dec_legal = 1'b0;
    endcase
  end

  // Completion on the same cycle as the limit takes priority over the trap.
  assign w_tmo = (MEM_TIMEOUT != 0) && (r_cnt == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)  w_next = S_DECODE;
        else if (w_tmo) w_next = S_TRAP;
      end
      S_DECODE: begin
        if (!stall) w_next = w_dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (!stall) begin
          case (r_cls)
            C_R, C_I, C_JAL:  w_next = S_WB;
            C_LOAD, C_STORE:  w_next = S_MEM;
            default:          w_next = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        if (mem_ready)  w_next = (r_cls == C_LOAD) ? S_WB : S_FETCH;
        else if (w_tmo) w_next = S_TRAP;
      end
      S_WB: begin
        if (!stall) w_next = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // Any state change clears the wait counter, so FETCH/MEM always start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls <= C_R;
    end else if (r_state == S_DECODE && !stall) begin
      r_cls <= w_dec_cls;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    trap       = 1'b0;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          case (r_cls)
            C_R: alu_op = 2'b10;
            C_I, C_LOAD, C_STORE: alu_src = 1'b1;
            C_BRANCH: begin
              alu_op = 2'b01;
              if (branch_taken) begin
                pc_src   = 2'b01;
                pc_write = !stall;
              end
            end
            default: begin
              pc_src   = 2'b10;
              pc_write = !stall;
            end
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (r_cls == C_STORE);
        end
        S_WB: begin
          reg_write  = !stall;
          mem_to_reg = (r_cls == C_LOAD);
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: each instruction is expanded into its
// expected per-cycle trace from the phase rules, with randomized waits/stalls.
module tb_multicycle_control_unit;

  localparam int TMO = 15;
  localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_T = 5;
  localparam int C_ILL = -1, C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       stall = 1'b0;
  logic       pc_write, ir_write, reg_write, alu_src, mem_to_reg, mem_req, mem_we, trap;
  logic [1:0] alu_op, pc_src;
  logic [2:0] state_o;
  logic [14:0] obs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(TMO), .ENABLE_JAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .stall(stall),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .mem_req(mem_req),
    .mem_we(mem_we), .trap(trap), .alu_op(alu_op), .pc_src(pc_src),
    .state_o(state_o)
  );

  assign obs = {state_o, pc_write, ir_write, reg_write, alu_src, mem_to_reg,
                mem_req, mem_we, trap, alu_op, pc_src};

  function automatic logic [14:0] mk(input int st, input logic pcw, irw, rw, asrc, m2r,
                                     mreq, mwe, trp, input logic [1:0] aop, psrc);
    return {3'(st), pcw, irw, rw, asrc, m2r, mreq, mwe, trp, aop, psrc};
  endfunction

  function automatic int classify(input logic [6:0] o);
    case (o)
      OP_R:    return C_R;
      OP_I:    return C_I;
      OP_LD:   return C_LD;
      OP_ST:   return C_ST;
      OP_BR:   return C_BR;
      OP_JAL:  return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  task automatic check(input logic [14:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed state=%0d ctl=%b expected state=%0d ctl=%b",
             tag, obs[14:12], obs[11:0], exp[14:12], exp[11:0]);
    end
  endtask

  task automatic step(input logic mr, bt, st, input logic [6:0] opc,
                      input logic [14:0] exp, input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = mr;
    branch_taken = bt;
    stall = st;
    opcode = opc;
    #1 check(exp, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b1;
    opcode = OP_R;
    #1 check(15'd0, tag);
    @(negedge clk);
    #1 check(15'd0, {tag, "_held"});
  endtask

  task automatic trap_hold(input int n);
    for (int k = 0; k < n; k++)
      step(rb(), rb(), rb(), rop(), mk(S_T, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00), "trap_hold");
  endtask

  // A memory phase: w cycles without mem_ready, then completion, or a trap once
  // the wait count exceeds the timeout.
  task automatic mem_phase(input int s, input logic we, input int w, output bit trapped);
    int n;
    n = (w > TMO) ? TMO + 1 : w;
    trapped = 1'b0;
    for (int k = 0; k < n; k++)
      step(1'b0, rb(), rb(), rop(), mk(s, 0, 0, 0, 0, 0, 1, we, 0, 2'b00, 2'b00),
           (s == S_F) ? "fetch_wait" : "mem_wait");
    if (w > TMO) begin
      step(rb(), rb(), rb(), rop(), mk(S_T, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00), "timeout_trap");
      trapped = 1'b1;
    end else begin
      step(1'b1, rb(), rb(), rop(),
           mk(s, s == S_F, s == S_F, 0, 0, 0, 1, we, 0, 2'b00, 2'b00),
           (s == S_F) ? "fetch_done" : "mem_done");
    end
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic bt,
                           input int wf, wm, sd, se, sw, output bit trapped);
    int c;
    logic s, b;
    logic [14:0] e;
    c = classify(opc);
    mem_phase(S_F, 1'b0, wf, trapped);
    if (trapped) return;
    for (int k = 0; k < sd; k++)
      step(rb(), rb(), 1'b1, opc, mk(S_D, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), "decode_stall");
    step(rb(), rb(), 1'b0, opc, mk(S_D, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), "decode");
    if (c == C_ILL) begin
      step(rb(), rb(), rb(), rop(), mk(S_T, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00), "illegal_trap");
      trapped = 1'b1;
      return;
    end
    // Opcode is scrambled from here on: later phases must use the decoded class.
    for (int k = 0; k <= se; k++) begin
      s = (k < se);
      b = (c == C_BR && k == se) ? bt : rb();
      case (c)
        C_R:             e = mk(S_E, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00);
        C_I, C_LD, C_ST: e = mk(S_E, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        C_BR:            e = mk(S_E, b && !s, 0, 0, 0, 0, 0, 0, 0, 2'b01, b ? 2'b01 : 2'b00);
        default:         e = mk(S_E, !s, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10);
      endcase
      step(rb(), b, s, rop(), e, s ? "exec_stall" : "exec");
    end
    if (c == C_BR) return;
    if (c == C_LD || c == C_ST) begin
      mem_phase(S_M, c == C_ST, wm, trapped);
      if (trapped || c == C_ST) return;
    end
    for (int k = 0; k <= sw; k++) begin
      s = (k < sw);
      step(rb(), rb(), s, rop(), mk(S_W, 0, 0, !s, 0, c == C_LD, 0, 0, 0, 2'b00, 2'b00),
           s ? "wb_stall" : "wb");
    end
  endtask

  initial begin
    bit tr;
    logic [6:0] ops [0:6];
    logic [6:0] op;
    int wf, wm;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST;
    ops[4] = OP_BR; ops[5] = OP_JAL; ops[6] = 7'b1111111;

    do_reset("reset");
    run_instr(OP_R, 1'b0, 0, 0, 0, 0, 0, tr);
    run_instr(OP_LD, 1'b0, 0, 3, 0, 0, 0, tr);
    run_instr(OP_BR, 1'b1, 0, 0, 0, 0, 0, tr);
    run_instr(OP_BR, 1'b0, 0, 0, 0, 0, 0, tr);
    run_instr(OP_ST, 1'b0, 1, 2, 0, 0, 0, tr);
    run_instr(OP_I, 1'b0, 0, 0, 0, 0, 0, tr);
    run_instr(OP_JAL, 1'b0, 0, 0, 0, 2, 0, tr);
    run_instr(OP_R, 1'b0, 0, 0, 0, 0, 5, tr);
    run_instr(OP_LD, 1'b0, 2, 1, 2, 3, 2, tr);

    run_instr(7'b1111111, 1'b0, 0, 0, 0, 0, 0, tr);
    trap_hold(20);
    do_reset("reset_from_trap");

    run_instr(OP_R, 1'b0, TMO + 1, 0, 0, 0, 0, tr);
    trap_hold(2);
    do_reset("reset_after_fetch_timeout");
    run_instr(OP_R, 1'b0, TMO, 0, 0, 0, 0, tr);
    run_instr(OP_LD, 1'b0, 0, TMO + 1, 0, 0, 0, tr);
    trap_hold(2);
    do_reset("reset_after_mem_timeout");
    run_instr(OP_ST, 1'b0, 0, TMO, 0, 0, 0, tr);

    step(1'b1, 1'b0, 1'b0, rop(), mk(S_F, 1, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00), "abort_fetch");
    step(1'b0, 1'b0, 1'b0, OP_LD, mk(S_D, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), "abort_decode");
    step(1'b0, 1'b0, 1'b0, rop(), mk(S_E, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00), "abort_exec");
    step(1'b0, 1'b0, 1'b0, rop(), mk(S_M, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00), "abort_mem");
    do_reset("reset_in_mem");

    repeat (60) begin
      op = ($urandom_range(0, 7) == 7) ? rop() : ops[$urandom_range(0, 6)];
      wf = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 1) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 1) : $urandom_range(0, 3);
      run_instr(op, rb(), wf, wm, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), tr);
      if (tr) begin
        trap_hold(2);
        do_reset("reset_random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, meaning: max consecutive wait cycles for mem_ready before trap; 0 disables the timeout.
REQ-002 Parameter ENABLE_JAL, default 1, meaning: 1 = JAL supported; 0 = JAL opcode treated as illegal.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 opcode  input  7  instruction opcode field from the instruction register.
REQ-006 mem_ready  input  1  memory completes the current request this cycle.
REQ-007 branch_taken  input  1  ALU branch condition result, valid in EXEC.
REQ-008 stall  input  1  external hold request, e.g. audio FIFO full.
REQ-009 pc_write, ir_write, reg_write, alu_src, mem_to_reg, mem_req, mem_we, trap  output  1 each  datapath controls and sticky trap flag.
REQ-010 alu_op  output  2  00 add, 01 compare/branch, 10 funct-decoded.
REQ-011 pc_src  output  2  00 PC+4, 01 branch target, 10 jump target.
REQ-012 state_o  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Function
REQ-013 States SHALL be FETCH, DECODE, EXEC, MEM, WB and TRAP; all outputs not stated as asserted for a state SHALL be 0.
REQ-014 FETCH: mem_req=1, mem_we=0; on mem_ready, ir_write=1, pc_write=1 and pc_src=00 for that cycle, next state DECODE; otherwise remain in FETCH.
REQ-015 DECODE SHALL register the instruction class from opcode: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111 (only if ENABLE_JAL=1).
REQ-016 DECODE SHALL go to TRAP on any other opcode, otherwise to EXEC.
REQ-017 EXEC, R: alu_src=0, alu_op=10, next WB; I: alu_src=1, alu_op=00, next WB; LOAD/STORE: alu_src=1, alu_op=00, next MEM.
REQ-018 EXEC, BRANCH: alu_src=0, alu_op=01; if branch_taken, pc_write=1 and pc_src=01; next FETCH.
REQ-019 EXEC, JAL: pc_write=1, pc_src=10, next WB for the link write.
REQ-020 MEM: mem_req=1, mem_we=1 for STORE and 0 for LOAD; on mem_ready, LOAD goes to WB and STORE goes to FETCH.
REQ-021 WB: reg_write=1 for exactly one cycle, mem_to_reg=1 only for LOAD; next FETCH.
REQ-022 EXEC and WB SHALL use the class registered in DECODE, never the live opcode.
REQ-023 stall=1 in DECODE, EXEC or WB SHALL hold the state and force pc_write, ir_write and reg_write to 0 for that cycle.
REQ-024 stall SHALL be ignored in FETCH and MEM, so that a mem_ready is never lost.
REQ-025 Timeout counter: cleared on entry to FETCH or MEM; increments each cycle in those states with mem_ready=0; saturates; width sufficient for MEM_TIMEOUT.
REQ-026 When the counter equals MEM_TIMEOUT and mem_ready=0, the next state SHALL be TRAP; if mem_ready=1 on that same cycle, completion wins.
REQ-027 TRAP: trap=1 and all other outputs 0; TRAP is left only by reset.
REQ-028 Zero-wait latency in cycles: R/I/JAL 4, LOAD 5, STORE 4, BRANCH 3.

Reset
REQ-029 rst_n=0 SHALL immediately force state FETCH, counter 0, registered class R, and all outputs 0 except that mem_req is 0 while reset is held.
REQ-030 Reset asserted mid-instruction, including in MEM or TRAP, SHALL abort the instruction with no further pc_write or reg_write.
REQ-031 After rst_n deasserts, the first rising edge SHALL begin FETCH with mem_req=1.

Verification
REQ-032 ADD (0110011), mem_ready always 1 -> state_o 0,1,2,4,0; reg_write=1 only in cycle 4; alu_op=10 in EXEC.
REQ-033 LW (0000011), mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles; then WB with mem_to_reg=1; total 8 cycles.
REQ-034 BEQ (1100011) -> with branch_taken=1: pc_write=1, pc_src=01 in EXEC; with branch_taken=0: pc_write=0; both return to FETCH after 3 cycles.
REQ-035 Opcode 1111111 -> TRAP after DECODE with trap=1; trap stays 1 for 20 cycles; reset clears it to FETCH.
REQ-036 FETCH with mem_ready=0 and MEM_TIMEOUT=15 -> TRAP on cycle 16; a repeat with mem_ready=1 on the 16th wait cycle -> DECODE, no trap.
REQ-037 stall=1 for 5 cycles in WB -> reg_write=0 while stalled; exactly one reg_write pulse after release; stall=1 in FETCH has no effect.
